// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg -- shared vending-machine definitions
//
// Holds the change-dispenser state encoding and the coin denominations.
// The coin-accepting machine uses the same denomination constants.
//
// Contents:
//   CNY_1 / CNY_2 / CNY_5        coin values in CNY (4-bit)
//   COIN_*_BIT                   bit positions in the one-hot coin select
//   ST_*                         dispenser FSM state encoding (3-bit)
//   greedy_coin()                largest coin not exceeding a change amount
// ---------------------------------------------------------------------------
package vm_pkg;

   localparam logic [3:0] CNY_1 = 4'd1;
   localparam logic [3:0] CNY_2 = 4'd2;
   localparam logic [3:0] CNY_5 = 4'd5;

   localparam int unsigned COIN_1_BIT = 0;
   localparam int unsigned COIN_2_BIT = 1;
   localparam int unsigned COIN_5_BIT = 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_VEND  = 3'd1;
   localparam logic [2:0] ST_CALC  = 3'd2;
   localparam logic [2:0] ST_EJECT = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd5;

   // Largest denomination that fits in the remaining change; 0 when none is owed.
   function automatic logic [3:0] greedy_coin(input logic [3:0] change);
      logic [3:0] coin;
      coin = '0;
      if (change >= CNY_5) begin
         coin = CNY_5;
      end else if (change >= CNY_2) begin
         coin = CNY_2;
      end else if (change >= CNY_1) begin
         coin = CNY_1;
      end
      return coin;
   endfunction

endpackage

// File: rtl/change_coin_sel.sv
// ---------------------------------------------------------------------------
// change_coin_sel -- greedy coin selection (combinational)
//
// Ports:
//   change    in   4  remaining change owed in CNY
//   coin_sel  out  3  one-hot select: bit0 = 1 CNY, bit1 = 2 CNY, bit2 = 5 CNY
//                     (all zero when change is 0)
//   coin_val  out  4  value of the selected coin in CNY (0 when none)
// ---------------------------------------------------------------------------
module change_coin_sel
   import vm_pkg::*;
(
   input  logic [3:0] change,
   output logic [2:0] coin_sel,
   output logic [3:0] coin_val
);

   always_comb begin
      coin_sel = '0;
      coin_val = greedy_coin(change);
      case (coin_val)
         CNY_5:   coin_sel[COIN_5_BIT] = 1'b1;
         CNY_2:   coin_sel[COIN_2_BIT] = 1'b1;
         CNY_1:   coin_sel[COIN_1_BIT] = 1'b1;
         default: coin_sel = '0;
      endcase
   end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser -- product release and greedy change payout FSM
//
// Parameters:
//   PRICE        product price in CNY (1..15)
//   ACK_TIMEOUT  cycles to wait for a coin-eject acknowledge (1..255),
//                only used when CHANGE_TIMEOUT_EN is defined
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous active-low reset
//   i_start      in   1  purchase attempt pulse (honoured in IDLE only)
//   i_credit     in   4  inserted credit in CNY, sampled with i_start
//   i_coin_ack   in   1  coin mechanism ejected the requested coin
//   o_item       out  1  release-product pulse
//   o_one_cny    out  1  eject 1 CNY request, held until acknowledged
//   o_two_cny    out  1  eject 2 CNY request, held until acknowledged
//   o_five_cny   out  1  eject 5 CNY request, held until acknowledged
//   o_busy       out  1  high in every state except IDLE
//   o_done       out  1  transaction-complete pulse
//   o_error      out  1  (CHANGE_TIMEOUT_EN only) ack timeout, held until rst
//
// Build option: define CHANGE_TIMEOUT_EN to add the eject-ack timeout and
// the ERR state. Without it EJECT waits for the ack indefinitely.
// ---------------------------------------------------------------------------
module change_dispenser
   import vm_pkg::*;
#(
   parameter int PRICE       = 6,
   parameter int ACK_TIMEOUT = 15
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [3:0] i_credit,
   input  logic       i_coin_ack,
   output logic       o_item,
   output logic       o_one_cny,
   output logic       o_two_cny,
   output logic       o_five_cny,
   output logic       o_busy,
   output logic       o_done
`ifdef CHANGE_TIMEOUT_EN
   ,
   output logic       o_error
`endif
);

   localparam logic [3:0] PRICE_V = 4'(PRICE);

   logic [2:0] state,      state_d;
   logic [3:0] change,     change_d;
   logic [2:0] coin_sel_q, coin_sel_d;
   logic [3:0] coin_val_q, coin_val_d;

   logic [2:0] sel_c;
   logic [3:0] val_c;

`ifdef CHANGE_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
   logic [7:0] wait_cnt, wait_cnt_d;
`endif

   change_coin_sel u_coin_sel (
      .change   (change),
      .coin_sel (sel_c),
      .coin_val (val_c)
   );

   // ---------------------------------------------------------------------
   // Next-state logic. The coin chosen in CALC is registered so the eject
   // request and the amount subtracted on ack stay fixed for the whole
   // EJECT wait.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state;
      change_d   = change;
      coin_sel_d = coin_sel_q;
      coin_val_d = coin_val_q;
`ifdef CHANGE_TIMEOUT_EN
      wait_cnt_d = wait_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_credit >= PRICE_V) begin
                  change_d = i_credit - PRICE_V;
                  state_d  = ST_VEND;
               end else begin
                  change_d = i_credit;
                  state_d  = ST_CALC;
               end
            end
         end
         ST_VEND: begin
            state_d = ST_CALC;
         end
         ST_CALC: begin
            if (change == '0) begin
               state_d = ST_DONE;
            end else begin
               coin_sel_d = sel_c;
               coin_val_d = val_c;
               state_d    = ST_EJECT;
`ifdef CHANGE_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         ST_EJECT: begin
            if (i_coin_ack) begin
               // Greedy choice guarantees coin_val_q <= change.
               change_d = change - coin_val_q;
               state_d  = ST_CALC;
            end
`ifdef CHANGE_TIMEOUT_EN
            else if (wait_cnt == TO_LAST) begin
               state_d = ST_ERR;
            end else begin
               wait_cnt_d = wait_cnt + 8'd1;
            end
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
`ifdef CHANGE_TIMEOUT_EN
         ST_ERR: begin
            state_d = ST_ERR;
         end
`endif
         default: begin
            state_d  = ST_IDLE;
            change_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         change     <= '0;
         coin_sel_q <= '0;
         coin_val_q <= '0;
`ifdef CHANGE_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         state      <= state_d;
         change     <= change_d;
         coin_sel_q <= coin_sel_d;
         coin_val_q <= coin_val_d;
`ifdef CHANGE_TIMEOUT_EN
         wait_cnt   <= wait_cnt_d;
`endif
      end
   end

   // Outputs decode the registered state only, so reset clears them at once.
   always_comb begin
      o_item     = (state == ST_VEND);
      o_one_cny  = (state == ST_EJECT) && coin_sel_q[COIN_1_BIT];
      o_two_cny  = (state == ST_EJECT) && coin_sel_q[COIN_2_BIT];
      o_five_cny = (state == ST_EJECT) && coin_sel_q[COIN_5_BIT];
      o_busy     = (state != ST_IDLE);
      o_done     = (state == ST_DONE);
`ifdef CHANGE_TIMEOUT_EN
      o_error    = (state == ST_ERR);
`endif
   end

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser -- scoreboard bench for change_dispenser
// Build with CHANGE_TIMEOUT_EN defined to include the ack-timeout scenario.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

   localparam int PRICE       = 6;
   localparam int ACK_TIMEOUT = 15;
   localparam int EV_ITEM     = 100;
   localparam int EV_DONE     = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_start = 1'b0;
   logic [3:0] i_credit = '0;
   logic       i_coin_ack = 1'b0;
   logic       o_item, o_one_cny, o_two_cny, o_five_cny, o_busy, o_done;
`ifdef CHANGE_TIMEOUT_EN
   logic       o_error;
`endif

   change_dispenser #(.PRICE(PRICE), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_credit   (i_credit),
      .i_coin_ack (i_coin_ack),
      .o_item     (o_item),
      .o_one_cny  (o_one_cny),
      .o_two_cny  (o_two_cny),
      .o_five_cny (o_five_cny),
      .o_busy     (o_busy),
`ifdef CHANGE_TIMEOUT_EN
      .o_error    (o_error),
`endif
      .o_done     (o_done)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   logic ack_s    = 1'b0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      ack_s <= i_coin_ack;
   end

   typedef struct {
      int ev;
      int at;   // required cycle, -1 = any
   } exp_t;
   exp_t sb[$];

   // acker controls
   bit ack_en   = 1'b1;
   int ack_min  = 0;
   int ack_max  = 0;
   bit stray_en = 1'b0;
   bit hold_chk = 1'b1;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: the event sequence one purchase must produce.
   task automatic push_txn(input int credit, input int start_cyc);
      exp_t e;
      int   ch;
      int   coin;
      bit   vend;
      vend = (credit >= PRICE);
      ch   = vend ? credit - PRICE : credit;
      if (vend) begin
         e.ev = EV_ITEM; e.at = start_cyc + 1; sb.push_back(e);
      end
      e.ev = EV_DONE;
      e.at = (ch == 0) ? (vend ? start_cyc + 3 : start_cyc + 2) : -1;
      while (ch > 0) begin
         coin = (ch >= 5) ? 5 : (ch >= 2) ? 2 : 1;
         sb.push_back('{ev: coin, at: -1});
         ch -= coin;
      end
      sb.push_back(e);
   endtask

   task automatic got(input int ev);
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got %0d, expected none (cycle %0d)", ev, cyc);
      end else begin
         e = sb.pop_front();
         check("event_seq", ev, e.ev);
         if (e.at >= 0) check("event_cycle", cyc, e.at);
      end
   endtask

   // Monitor: samples outputs on the falling edge.
   logic [2:0] req, req_prev;
   initial begin
      req_prev = '0;
      forever begin
         @(negedge clk);
         req = {o_five_cny, o_two_cny, o_one_cny};
         if (rst) begin
            if (req != 3'b000) check("req_onehot", $countones(req), 1);
            if (hold_chk && req_prev != 3'b000 && !ack_s) check("req_held", int'(req), int'(req_prev));
            if (req_prev != 3'b000 && ack_s) check("req_drop_after_ack", int'(req), 0);
            if (o_item) got(EV_ITEM);
            if (req != 3'b000 && req_prev == 3'b000)
               got(req[2] ? 5 : req[1] ? 2 : 1);
            if (o_done) got(EV_DONE);
            req_prev = req;
         end else begin
            req_prev = '0;
         end
      end
   end

   // Coin mechanism model: acks each request after a random delay, plus stray acks.
   initial begin
      int dly;
      bit armed;
      armed = 1'b0;
      dly   = 0;
      forever begin
         @(negedge clk);
         i_coin_ack = 1'b0;
         if (ack_en && (o_one_cny || o_two_cny || o_five_cny)) begin
            if (!armed) begin
               dly   = $urandom_range(ack_max, ack_min);
               armed = 1'b1;
            end
            if (dly == 0) begin
               i_coin_ack = 1'b1;
               armed      = 1'b0;
            end else begin
               dly--;
            end
         end else begin
            armed = 1'b0;
            if (ack_en && stray_en && $urandom_range(3, 0) == 0) i_coin_ack = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (o_busy) check("idle_timeout", 1, 0);
   endtask

   task automatic start_txn(input int credit, input bit mid);
      wait_idle();
      @(negedge clk);
      push_txn(credit, cyc);
      i_start  = 1'b1;
      i_credit = 4'(credit);
      @(negedge clk);
      i_start  = 1'b0;
      i_credit = 4'($urandom_range(15, 0));
      if (mid) begin
         repeat ($urandom_range(3, 0)) @(negedge clk);
         if (o_busy) begin
            i_start  = 1'b1;
            i_credit = 4'($urandom_range(15, 0));
            @(negedge clk);
            i_start  = 1'b0;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_item"}, int'(o_item), 0);
      check({tag, "_one"},  int'(o_one_cny), 0);
      check({tag, "_two"},  int'(o_two_cny), 0);
      check({tag, "_five"}, int'(o_five_cny), 0);
      check({tag, "_busy"}, int'(o_busy), 0);
      check({tag, "_done"}, int'(o_done), 0);
`ifdef CHANGE_TIMEOUT_EN
      check({tag, "_error"}, int'(o_error), 0);
`endif
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_all_zero("reset");

      // first i_start right at reset release must be honoured
      @(negedge clk);
      rst = 1'b1;
      push_txn(6, cyc);
      i_start  = 1'b1;
      i_credit = 4'd6;
      @(negedge clk);
      i_start = 1'b0;

      // directed: immediate acks
      ack_min = 0; ack_max = 0;
      start_txn(13, 1'b0);
      start_txn(4, 1'b0);
      start_txn(0, 1'b0);
      start_txn(15, 1'b0);
      start_txn(5, 1'b0);

      // directed: ack delayed 5 cycles, extra i_start mid-transaction
      ack_min = 5; ack_max = 5;
      start_txn(9, 1'b1);
      start_txn(10, 1'b1);
      wait_idle();
      check("sb_empty_directed", sb.size(), 0);

      // reset while o_five_cny is high
      ack_en = 1'b0;
      start_txn(15, 1'b0);
      n = 0;
      while (!o_five_cny && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("five_before_reset", int'(o_five_cny), 1);
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      ack_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_busy", int'(o_busy), 0);
         check("post_reset_req", int'({o_five_cny, o_two_cny, o_one_cny}), 0);
      end
      ack_min = 0; ack_max = 2;
      start_txn(8, 1'b0);

      // randomized purchases with stray acks and mid-transaction starts
      stray_en = 1'b1;
      ack_min = 0; ack_max = 4;
      for (int i = 0; i < 40; i++) begin
         start_txn($urandom_range(15, 0), 1'($urandom_range(1, 0)));
      end
      wait_idle();
      repeat (2) @(negedge clk);
      check("sb_empty_random", sb.size(), 0);
      stray_en = 1'b0;

`ifdef CHANGE_TIMEOUT_EN
      // never acknowledge: request must drop after ACK_TIMEOUT cycles
      ack_en   = 1'b0;
      hold_chk = 1'b0;
      start_txn(7, 1'b0);
      n = 0;
      while (!o_one_cny && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (o_one_cny && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("timeout_req_cycles", n, ACK_TIMEOUT);
      repeat (5) begin
         check("err_error", int'(o_error), 1);
         check("err_busy", int'(o_busy), 1);
         check("err_req", int'({o_five_cny, o_two_cny, o_one_cny}), 0);
         @(negedge clk);
      end
      check("timeout_sb_left", sb.size(), 1);
      sb.delete();
      #2 rst = 1'b0;
      #1 check_all_zero("err_reset");
      @(negedge clk);
      rst      = 1'b1;
      ack_en   = 1'b1;
      hold_chk = 1'b1;
      start_txn(11, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);
      check("sb_empty_after_err", sb.size(), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PRICE, default 6, product price in CNY (1..15).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, maximum cycles to wait for coin-eject acknowledge (1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  one-cycle pulse: a purchase attempt with credit i_credit.
REQ-006 i_credit  input  4  inserted credit in CNY, sampled only when i_start=1 in IDLE.
REQ-007 i_coin_ack  input  1  coin mechanism has ejected the currently requested coin.
REQ-008 o_item  output  1  one-cycle pulse: release one product.
REQ-009 o_one_cny / o_two_cny / o_five_cny  output  1 each  coin-eject request, at most one high, held until acknowledged.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle pulse: transaction complete, all change paid.

Function
REQ-012 States SHALL be IDLE, VEND, CALC, EJECT, DONE (plus ERR when REQ-026 is compiled in).
REQ-013 IDLE: i_start=1 with i_credit>=PRICE SHALL go to VEND and latch change=i_credit-PRICE.
REQ-014 IDLE: i_start=1 with i_credit<PRICE SHALL skip VEND, latch change=i_credit, and go to CALC (full refund, no item).
REQ-015 i_start outside IDLE SHALL be ignored.
REQ-016 VEND SHALL assert o_item for exactly one cycle and then go to CALC.
REQ-017 CALC: change=0 SHALL go to DONE; otherwise it SHALL select the greedy coin (5 if change>=5, else 2 if >=2, else 1) and go to EJECT.
REQ-018 EJECT SHALL hold exactly the selected coin request high from the cycle after CALC until the cycle i_coin_ack=1 is sampled.
REQ-019 On that ack, the coin value SHALL be subtracted from change, the request SHALL drop in the next cycle, and the FSM SHALL return to CALC.
REQ-020 i_coin_ack while no coin request is high SHALL be ignored.
REQ-021 DONE SHALL assert o_done for one cycle and then return to IDLE.
REQ-022 change SHALL be a 4-bit unsigned value and SHALL never underflow (greedy selection guarantees coin<=change).
REQ-023 Latency: i_start to o_item SHALL be 1 cycle; with zero change, i_start to o_done SHALL be 3 cycles.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, change=0, and all outputs to 0, including mid-eject, with no partial payout resumed after release.
REQ-025 The first i_start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-026 With CHANGE_TIMEOUT_EN defined:
- An 8-bit wait counter SHALL count EJECT cycles without ack.
- On reaching ACK_TIMEOUT, the request SHALL drop and the FSM SHALL enter ERR.
- ERR SHALL assert output o_error (1 bit, reset 0) and hold until rst.
- o_busy SHALL remain high in ERR.
REQ-027 Without CHANGE_TIMEOUT_EN: no counter, no ERR state, no o_error port; EJECT SHALL wait indefinitely.

Structure
REQ-028 Shared package vm_pkg SHALL hold the state encoding and the coin value constants CNY_1=1, CNY_2=2, CNY_5=5, which are also used by the coin-accepting machine.
REQ-029 Greedy selection SHALL be a sub-module change_coin_sel: combinational, change in, one-hot coin select and coin value out.

Verification
REQ-030 The bench SHALL cover these scenarios:
- i_credit=6, i_start -> o_item one cycle, no coin requests, o_done 2 cycles later.
- i_credit=13, immediate acks -> o_item, then o_five_cny, then o_two_cny, then o_done; total change 7.
- i_credit=4 (below PRICE) -> no o_item; o_two_cny, o_two_cny, then o_done.
- i_credit=9, ack delayed 5 cycles, i_start pulsed mid-transaction -> o_two_cny held exactly until ack, extra i_start ignored, then o_one_cny, then o_done.
- rst asserted while o_five_cny is high -> outputs 0 asynchronously; after release, FSM is in IDLE and no request is pending.
- CHANGE_TIMEOUT_EN, i_credit=7, never ack -> o_one_cny drops after 15 cycles, o_error=1, o_busy=1 until rst.
